main_ctrl_fsm: RTL and testbench

- Moore main controller for the multicycle ARM-subset core.
- Sequences fetch, decode, memory, data-processing and branch steps.
- Drives NextPC, RegW, MemW and Branch into the conditional-logic block, which gates them with the delayed condition result.
- Also drives the datapath mux selects, IRWrite and the ALUOp request consumed by the ALU decoder.

---
 rtl/main_ctrl_fsm_if.sv | 30 +++
 rtl/main_ctrl_fsm.sv | 151 +++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_ctrl_fsm_if.sv
// Control bundle between the multicycle main controller and the datapath/condition logic.
// The controller takes the IR opcode fields and drives the mux selects and write requests.
interface main_ctrl_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Illegal, State
    );

    modport slave (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
               NextPC, RegW, MemW, Branch, Illegal, State
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// Moore main controller for the multicycle ARM-subset core: sequences fetch, decode,
// memory, data-processing and branch steps with every output registered from the next state.
module main_ctrl_fsm #(
    parameter bit HALT_ON_UNKNOWN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    main_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        UNKNOWN  = 4'd10
    } state_t;

    typedef struct packed {
        logic       IRWrite;
        logic       AdrSrc;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ResultSrc;
        logic       ALUOp;
        logic       NextPC;
        logic       RegW;
        logic       MemW;
        logic       Branch;
        logic       Illegal;
    } ctrl_t;

    state_t state;
    ctrl_t  ctrl;

    // Only Funct[5] (immediate) and Funct[0] (load) steer the sequence.
    logic funct_unused;
    assign funct_unused = ^bus.Funct[4:1];

    function automatic state_t next_state(input state_t s, input logic [1:0] op,
                                          input logic imm, input logic load);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:    n = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   n = imm ? EXECUTEI : EXECUTER;
                    2'b01:   n = MEMADR;
                    2'b10:   n = BRANCH;
                    default: n = UNKNOWN;
                endcase
            end
            MEMADR:   n = load ? MEMREAD : MEMWRITE;
            MEMREAD:  n = MEMWB;
            MEMWB:    n = FETCH;
            MEMWRITE: n = FETCH;
            EXECUTER: n = ALUWB;
            EXECUTEI: n = ALUWB;
            ALUWB:    n = FETCH;
            BRANCH:   n = FETCH;
            // UNKNOWN and the unused codes 11-15 share the same exit policy.
            default:  n = HALT_ON_UNKNOWN ? UNKNOWN : FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ALUSrcA   = 1'b1;
                c.ALUSrcB   = 2'b10;
                c.ResultSrc = 2'b10;
                c.IRWrite   = 1'b1;
                c.NextPC    = 1'b1;
            end
            DECODE: begin
                c.ALUSrcA   = 1'b1;
                c.ALUSrcB   = 2'b10;
                c.ResultSrc = 2'b10;
            end
            MEMADR: begin
                c.ALUSrcB   = 2'b01;
            end
            MEMREAD: begin
                c.AdrSrc    = 1'b1;
            end
            MEMWB: begin
                c.ResultSrc = 2'b01;
                c.RegW      = 1'b1;
            end
            MEMWRITE: begin
                c.AdrSrc    = 1'b1;
                c.MemW      = 1'b1;
            end
            EXECUTER: begin
                c.ALUOp     = 1'b1;
            end
            EXECUTEI: begin
                c.ALUSrcB   = 2'b01;
                c.ALUOp     = 1'b1;
            end
            ALUWB: begin
                c.RegW      = 1'b1;
            end
            BRANCH: begin
                c.ALUSrcB   = 2'b01;
                c.ResultSrc = 2'b10;
                c.Branch    = 1'b1;
            end
            default: begin
                c.Illegal   = 1'b1;
            end
        endcase
        return c;
    endfunction

    // Outputs are registered from the next state so they always match the state register
    // without any combinational path from Op/Funct.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ctrl  <= decode(FETCH);
        end else begin
            state <= next_state(state, bus.Op, bus.Funct[5], bus.Funct[0]);
            ctrl  <= decode(next_state(state, bus.Op, bus.Funct[5], bus.Funct[0]));
        end
    end

    assign bus.IRWrite   = ctrl.IRWrite;
    assign bus.AdrSrc    = ctrl.AdrSrc;
    assign bus.ALUSrcA   = ctrl.ALUSrcA;
    assign bus.ALUSrcB   = ctrl.ALUSrcB;
    assign bus.ResultSrc = ctrl.ResultSrc;
    assign bus.ALUOp     = ctrl.ALUOp;
    assign bus.NextPC    = ctrl.NextPC;
    assign bus.RegW      = ctrl.RegW;
    assign bus.MemW      = ctrl.MemW;
    assign bus.Branch    = ctrl.Branch;
    assign bus.Illegal   = ctrl.Illegal;
    assign bus.State     = state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm: runs one sticky-UNKNOWN and one non-sticky instance
// side by side and compares state plus every output against a hand-built per-state table.
module tb_main_ctrl_fsm;

    logic clk;
    logic clk_en;
    logic reset;
    int   checks;
    int   fails;

    main_ctrl_fsm_if bus_h ();
    main_ctrl_fsm_if bus_n ();

    main_ctrl_fsm #(.HALT_ON_UNKNOWN(1'b1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h.master));
    main_ctrl_fsm #(.HALT_ON_UNKNOWN(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = clk_en ? ~clk : 1'b0;
    end

    // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch, Illegal}
    logic [12:0] obs_h;
    logic [12:0] obs_n;
    assign obs_h = {bus_h.IRWrite, bus_h.AdrSrc, bus_h.ALUSrcA, bus_h.ALUSrcB, bus_h.ResultSrc,
                    bus_h.ALUOp, bus_h.NextPC, bus_h.RegW, bus_h.MemW, bus_h.Branch, bus_h.Illegal};
    assign obs_n = {bus_n.IRWrite, bus_n.AdrSrc, bus_n.ALUSrcA, bus_n.ALUSrcB, bus_n.ResultSrc,
                    bus_n.ALUOp, bus_n.NextPC, bus_n.RegW, bus_n.MemW, bus_n.Branch, bus_n.Illegal};

    function automatic logic [12:0] exp_out(input logic [3:0] s);
        case (s)
            4'd0:    return 13'b1_0_1_10_10_0_1_0_0_0_0;
            4'd1:    return 13'b0_0_1_10_10_0_0_0_0_0_0;
            4'd2:    return 13'b0_0_0_01_00_0_0_0_0_0_0;
            4'd3:    return 13'b0_1_0_00_00_0_0_0_0_0_0;
            4'd4:    return 13'b0_0_0_00_01_0_0_1_0_0_0;
            4'd5:    return 13'b0_1_0_00_00_0_0_0_1_0_0;
            4'd6:    return 13'b0_0_0_00_00_1_0_0_0_0_0;
            4'd7:    return 13'b0_0_0_01_00_1_0_0_0_0_0;
            4'd8:    return 13'b0_0_0_00_00_0_0_1_0_0_0;
            4'd9:    return 13'b0_0_0_01_10_0_0_0_0_1_0;
            default: return 13'b0_0_0_00_00_0_0_0_0_0_1;
        endcase
    endfunction

    task automatic set_ops(input logic [1:0] op, input logic [5:0] funct);
        bus_h.Op = op; bus_h.Funct = funct;
        bus_n.Op = op; bus_n.Funct = funct;
    endtask

    // Pulses reset away from the clock edge; returns with both DUTs in FETCH.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] seq [3];
        seq = '{4'd0, 4'd1, 4'd6};
        set_ops(2'b00, 6'b001000);
        clk_en = 1'b0;
        reset  = 1'b1;
        #3 reset = 1'b0;
        #10;
        checks++;
        if (bus_h.State !== 4'd0 || obs_h !== exp_out(4'd0)) begin
            $display("FAIL reset_noclk_h: state=%0d out=%b expected state=0 out=%b", bus_h.State, obs_h, exp_out(4'd0));
            fails++;
        end
        checks++;
        if (bus_n.State !== 4'd0 || obs_n !== exp_out(4'd0)) begin
            $display("FAIL reset_noclk_n: state=%0d out=%b expected state=0 out=%b", bus_n.State, obs_n, exp_out(4'd0));
            fails++;
        end
        clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus_h.State !== 4'd0 || bus_h.RegW !== 1'b0 || bus_h.MemW !== 1'b0 || obs_h !== exp_out(4'd0)) begin
                $display("FAIL reset_held cycle %0d: state=%0d out=%b expected state=0 out=%b", i, bus_h.State, obs_h, exp_out(4'd0));
                fails++;
            end
        end
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq[k] || obs_h !== exp_out(seq[k])) begin
                $display("FAIL reset_release step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
    endtask

    task automatic test_ldr();
        logic [3:0] seq [6];
        seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        set_ops(2'b01, 6'b011001);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq[k] || obs_h !== exp_out(seq[k])) begin
                $display("FAIL ldr_h step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq[k], exp_out(seq[k]));
                fails++;
            end
            checks++;
            if (bus_n.State !== seq[k] || obs_n !== exp_out(seq[k])) begin
                $display("FAIL ldr_n step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_n.State, obs_n, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
    endtask

    task automatic test_str();
        logic [3:0] seq [5];
        seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        set_ops(2'b01, 6'b011000);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq[k] || obs_h !== exp_out(seq[k])) begin
                $display("FAIL str step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
    endtask

    task automatic test_dp();
        logic [3:0] seq_r [5];
        logic [3:0] seq_i [5];
        seq_r = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        seq_i = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        set_ops(2'b00, 6'b001000);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq_r[k] || obs_h !== exp_out(seq_r[k])) begin
                $display("FAIL dp_reg step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq_r[k], exp_out(seq_r[k]));
                fails++;
            end
        end
        set_ops(2'b00, 6'b101000);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq_i[k] || obs_h !== exp_out(seq_i[k])) begin
                $display("FAIL dp_imm step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq_i[k], exp_out(seq_i[k]));
                fails++;
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] seq [4];
        seq = '{4'd0, 4'd1, 4'd9, 4'd0};
        set_ops(2'b10, 6'b000000);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_n.State !== seq[k] || obs_n !== exp_out(seq[k])) begin
                $display("FAIL branch step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_n.State, obs_n, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
    endtask

    task automatic test_illegal();
        logic [3:0] seq [3];
        seq = '{4'd0, 4'd1, 4'd10};
        set_ops(2'b11, 6'b000000);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (bus_h.State !== seq[k] || obs_h !== exp_out(seq[k])) begin
                $display("FAIL illegal_h step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq[k], exp_out(seq[k]));
                fails++;
            end
            checks++;
            if (bus_n.State !== seq[k] || obs_n !== exp_out(seq[k])) begin
                $display("FAIL illegal_n step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_n.State, obs_n, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus_h.State !== 4'd10 || bus_h.Illegal !== 1'b1 || obs_h !== exp_out(4'd10)) begin
                $display("FAIL illegal_sticky cycle %0d: state=%0d out=%b expected state=10 out=%b", i, bus_h.State, obs_h, exp_out(4'd10));
                fails++;
            end
            if (i == 1) begin
                checks++;
                if (bus_n.State !== 4'd0 || obs_n !== exp_out(4'd0)) begin
                    $display("FAIL illegal_return: state=%0d out=%b expected state=0 out=%b", bus_n.State, obs_n, exp_out(4'd0));
                    fails++;
                end
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_h.State !== 4'd0 || obs_h !== exp_out(4'd0)) begin
            $display("FAIL illegal_async_reset: state=%0d out=%b expected state=0 out=%b", bus_h.State, obs_h, exp_out(4'd0));
            fails++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_memread();
        set_ops(2'b01, 6'b011001);
        do_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus_h.State !== 4'd3) begin
            $display("FAIL memread_reach: state=%0d expected state=3", bus_h.State);
            fails++;
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (bus_h.State !== 4'd0 || obs_h !== exp_out(4'd0)) begin
            $display("FAIL memread_async_reset: state=%0d out=%b expected state=0 out=%b", bus_h.State, obs_h, exp_out(4'd0));
            fails++;
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Changes Op/Funct only outside DECODE/MEMADR to show they are ignored there.
    task automatic test_back_to_back();
        logic [3:0] seq [12];
        seq = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        set_ops(2'b01, 6'b011000);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) set_ops(2'b10, 6'b111111);
            if (k == 7) set_ops(2'b00, 6'b001000);
            if (k == 9) set_ops(2'b11, 6'b101001);
            checks++;
            if (bus_h.State !== seq[k] || obs_h !== exp_out(seq[k])) begin
                $display("FAIL back_to_back step %0d: state=%0d out=%b expected state=%0d out=%b", k, bus_h.State, obs_h, seq[k], exp_out(seq[k]));
                fails++;
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        clk_en = 1'b0;
        reset  = 1'b1;
        set_ops(2'b00, 6'b000000);
        test_reset();
        test_ldr();
        test_str();
        test_dp();
        test_branch();
        test_illegal();
        test_reset_mid_memread();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
